// File: rtl/m3_hall_feedback_decoder.sv
// m3_hall_feedback_decoder: Hall line sync/debounce, sector and direction
// decode, step period measurement, stall and invalid-sensor detection.
module m3_hall_feedback_decoder #(
  parameter int DEB_CYC   = 8,
  parameter int PER_W     = 20,
  parameter int STALL_CYC = 500000
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             hallAi,
  input  logic             hallBi,
  input  logic             hallCi,
  input  logic             clrFaultI,
  output logic [2:0]       sectorO,
  output logic             sectorVldO,
  output logic             dirO,
  output logic             stepPulseO,
  output logic [PER_W-1:0] periodO,
  output logic             periodVldO,
  output logic             stallO,
  output logic             hallFaultO
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC);
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] STALL_LIM = PER_W'(STALL_CYC - 1);

  typedef enum logic [1:0] {INIT, SYNC1, RUN, FAULT} stateT;
  stateT stateQ, stateD;

  logic [2:0]       meta, synced, cand, acc;
  logic [2:0]       codeNow, codeSec;
  logic [DW-1:0]    debCnt;
  logic [PER_W-1:0] perCnt, perInc, perCntD;
  logic             accEv, codeVld, fwd, rev;
  logic             active, isStep, stallHit;
  logic [2:0]       sectorD;
  logic [PER_W-1:0] periodD;
  logic             sectorVldD, dirD, stepD;
  logic             perVldD, stallD, faultD;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= {hallAi, hallBi, hallCi};
      synced <= meta;
    end
  end

  // The accepted code only moves after DEB_CYC identical synced samples.
  assign accEv = (debCnt == DEB_MAX) && (cand != acc);

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cand   <= '0;
      debCnt <= '0;
      acc    <= '0;
    end else begin
      if (synced != cand) begin
        cand   <= synced;
        debCnt <= DW'(1);
      end else if (debCnt != DEB_MAX) begin
        debCnt <= debCnt + DW'(1);
      end
      if (accEv) acc <= cand;
    end
  end

  assign codeNow = accEv ? cand : acc;

  always_comb begin
    codeVld = 1'b1;
    codeSec = 3'd0;
    case (codeNow)
      3'b101:  codeSec = 3'd0;
      3'b100:  codeSec = 3'd1;
      3'b110:  codeSec = 3'd2;
      3'b010:  codeSec = 3'd3;
      3'b011:  codeSec = 3'd4;
      3'b001:  codeSec = 3'd5;
      default: codeVld = 1'b0;
    endcase
  end

  assign fwd = codeSec ==
    ((sectorO == 3'd5) ? 3'd0 : sectorO + 3'd1);
  assign rev = codeSec ==
    ((sectorO == 3'd0) ? 3'd5 : sectorO - 3'd1);

  assign active   = (stateQ == SYNC1) || (stateQ == RUN);
  assign isStep   = active && accEv && codeVld && (fwd || rev);
  assign perInc   = (perCnt == PER_MAX) ? PER_MAX
                                        : perCnt + PER_W'(1);
  assign stallHit = active && (perCnt >= STALL_LIM);

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) stateQ <= INIT;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      INIT: begin
        if (accEv && !codeVld) stateD = FAULT;
        else if (codeVld)      stateD = SYNC1;
      end
      SYNC1, RUN: begin
        if (accEv) begin
          if (!isStep)
            stateD = FAULT;
          else if (stateQ == SYNC1 || rev == dirO)
            stateD = RUN;
          else
            stateD = SYNC1;
        end else if (stallHit) begin
          stateD = SYNC1;
        end
      end
      FAULT: begin
        if (clrFaultI && codeVld) stateD = INIT;
      end
      default: stateD = INIT;
    endcase
  end

  always_comb begin
    sectorD    = sectorO;
    sectorVldD = sectorVldO;
    dirD       = dirO;
    stepD      = 1'b0;
    periodD    = periodO;
    perVldD    = 1'b0;
    stallD     = stallO;
    faultD     = hallFaultO;
    perCntD    = perInc;
    case (stateQ)
      INIT: begin
        stallD = 1'b0;
        if (accEv && !codeVld) begin
          faultD     = 1'b1;
          sectorVldD = 1'b0;
        end else if (codeVld) begin
          sectorD    = codeSec;
          sectorVldD = 1'b1;
          perCntD    = '0;
        end
      end
      SYNC1, RUN: begin
        if (isStep) begin
          stepD   = 1'b1;
          sectorD = codeSec;
          dirD    = rev;
          stallD  = 1'b0;
          perCntD = '0;
          if (stateQ == RUN && rev == dirO) begin
            periodD = perInc;
            perVldD = 1'b1;
          end
        end else if (accEv) begin
          faultD     = 1'b1;
          sectorVldD = 1'b0;
          stallD     = 1'b0;
        end else if (stallHit) begin
          stallD = 1'b1;
        end
      end
      FAULT: begin
        stallD     = 1'b0;
        sectorVldD = 1'b0;
        faultD     = !(clrFaultI && codeVld);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      sectorO    <= '0;
      sectorVldO <= 1'b0;
      dirO       <= 1'b0;
      stepPulseO <= 1'b0;
      periodO    <= '0;
      periodVldO <= 1'b0;
      stallO     <= 1'b0;
      hallFaultO <= 1'b0;
      perCnt     <= '0;
    end else begin
      sectorO    <= sectorD;
      sectorVldO <= sectorVldD;
      dirO       <= dirD;
      stepPulseO <= stepD;
      periodO    <= periodD;
      periodVldO <= perVldD;
      stallO     <= stallD;
      hallFaultO <= faultD;
      perCnt     <= perCntD;
    end
  end

endmodule

// File: tb/tb_m3_hall_feedback_decoder.sv
// Bench for m3_hall_feedback_decoder: timestamp-based reference model
// checked every cycle on two instances, plus directed literal checks.
module tb_m3_hall_feedback_decoder;

  localparam int DEB    = 8;
  localparam int PW     = 20;
  localparam int STALL0 = 3000;
  localparam int STALL1 = 100;
  localparam longint PMAXL = (longint'(1) << PW) - 1;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic hA = 1'b0, hB = 1'b0, hC = 1'b0;
  logic clr = 1'b0;

  logic [2:0]    secO  [2];
  logic          vldO  [2];
  logic          dirO  [2];
  logic          stepO [2];
  logic [PW-1:0] perO  [2];
  logic          pvO   [2];
  logic          stallO[2];
  logic          faultO[2];

  int total = 0;
  int bad = 0;
  int stepCnt[2] = '{0, 0};
  int pvCnt[2] = '{0, 0};

  always #5 clk = ~clk;

  m3_hall_feedback_decoder #(
    .DEB_CYC(DEB), .PER_W(PW), .STALL_CYC(STALL0)
  ) dut0 (
    .clkI(clk), .nRstI(nRst),
    .hallAi(hA), .hallBi(hB), .hallCi(hC),
    .clrFaultI(clr),
    .sectorO(secO[0]), .sectorVldO(vldO[0]),
    .dirO(dirO[0]), .stepPulseO(stepO[0]),
    .periodO(perO[0]), .periodVldO(pvO[0]),
    .stallO(stallO[0]), .hallFaultO(faultO[0])
  );

  m3_hall_feedback_decoder #(
    .DEB_CYC(DEB), .PER_W(PW), .STALL_CYC(STALL1)
  ) dut1 (
    .clkI(clk), .nRstI(nRst),
    .hallAi(hA), .hallBi(hB), .hallCi(hC),
    .clrFaultI(clr),
    .sectorO(secO[1]), .sectorVldO(vldO[1]),
    .dirO(dirO[1]), .stepPulseO(stepO[1]),
    .periodO(perO[1]), .periodVldO(pvO[1]),
    .stallO(stallO[1]), .hallFaultO(faultO[1])
  );

  // Reference model: raw-sample history plus step timestamps.
  logic [2:0]    hist[DEB+3];
  logic [2:0]    mAcc;
  longint        n;
  longint        tRef[2];
  longint        lim[2] = '{STALL0, STALL1};
  bit            inFault[2], havePos[2], armed[2];
  logic [2:0]    mSec[2];
  logic [PW-1:0] mPer[2];
  bit            mVld[2], mDir[2], mStep[2];
  bit            mPv[2], mStall[2], mFault[2];
  bit            ev, stable;
  logic [2:0]    cNew;

  function automatic int secOf(input logic [2:0] c);
    case (c)
      3'b101:  return 0;
      3'b100:  return 1;
      3'b110:  return 2;
      3'b010:  return 3;
      3'b011:  return 4;
      3'b001:  return 5;
      default: return -1;
    endcase
  endfunction

  task automatic enterFault(input int i);
    inFault[i] = 1; havePos[i] = 0; armed[i] = 0;
    mFault[i] = 1; mVld[i] = 0; mStall[i] = 0;
  endtask

  task automatic modelStep(input int i, input bit e);
    int s, d;
    bit dn;
    s = secOf(mAcc);
    mStep[i] = 0;
    mPv[i] = 0;
    if (inFault[i]) begin
      if (clr && s >= 0) begin
        inFault[i] = 0;
        mFault[i] = 0;
      end
    end else if (!havePos[i]) begin
      if (e && s < 0) enterFault(i);
      else if (s >= 0) begin
        mSec[i] = 3'(s); mVld[i] = 1;
        havePos[i] = 1; armed[i] = 0; tRef[i] = n;
      end
    end else if (e) begin
      if (s < 0) enterFault(i);
      else begin
        d = (s - int'(mSec[i]) + 6) % 6;
        if (d != 1 && d != 5) enterFault(i);
        else begin
          dn = (d == 5);
          if (armed[i] && dn == mDir[i]) begin
            mPer[i] = (n - tRef[i] >= PMAXL) ? PW'(PMAXL)
                                             : PW'(n - tRef[i]);
            mPv[i] = 1;
          end
          armed[i] = !(armed[i] && dn != mDir[i]);
          mDir[i] = dn; mSec[i] = 3'(s);
          mStep[i] = 1; mStall[i] = 0; tRef[i] = n;
        end
      end
    end else if (n - tRef[i] >= lim[i]) begin
      mStall[i] = 1;
      armed[i] = 0;
    end
  endtask

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      n = 0;
      mAcc = '0;
      for (int k = 0; k < DEB + 3; k++) hist[k] = '0;
      for (int i = 0; i < 2; i++) begin
        inFault[i] = 0; havePos[i] = 0; armed[i] = 0;
        mSec[i] = '0; mPer[i] = '0; tRef[i] = 0;
        mVld[i] = 0; mDir[i] = 0; mStep[i] = 0;
        mPv[i] = 0; mStall[i] = 0; mFault[i] = 0;
      end
    end else begin
      n++;
      for (int k = DEB + 2; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {hA, hB, hC};
      cNew = hist[3];
      stable = 1;
      for (int k = 3; k <= DEB + 2; k++)
        if (hist[k] != cNew) stable = 0;
      ev = stable && (cNew != mAcc);
      if (ev) mAcc = cNew;
      for (int i = 0; i < 2; i++) modelStep(i, ev);
    end
  end

  task automatic chk(input string nm, input longint got,
                     input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic cmp();
    logic [PW+8:0] g, w;
    for (int i = 0; i < 2; i++) begin
      g = {secO[i], vldO[i], dirO[i], stepO[i], perO[i],
           pvO[i], stallO[i], faultO[i]};
      w = {mSec[i], mVld[i], mDir[i], mStep[i], mPer[i],
           mPv[i], mStall[i], mFault[i]};
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL cycle inst%0d n=%0d got=%h want=%h",
                 i, n, g, w);
      end
      if (stepO[i] === 1'b1) stepCnt[i]++;
      if (pvO[i] === 1'b1) pvCnt[i]++;
    end
  endtask

  task automatic hold(input logic [2:0] code, input int cyc);
    {hA, hB, hC} = code;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  int s0, p0, p1, lat;

  initial begin
    {hA, hB, hC} = 3'b101;
    fork
      forever begin
        @(negedge clk);
        cmp();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", vldO[0], 0);
    chk("rst_fault", faultO[0], 0);
    nRst = 1'b1;

    hold(3'b101, 20);
    chk("t1_sec", secO[0], 0);
    chk("t1_vld", vldO[0], 1);
    chk("t1_steps", stepCnt[0], 0);

    s0 = stepCnt[0]; p0 = pvCnt[0]; p1 = pvCnt[1];
    hold(3'b100, 1000);
    hold(3'b110, 20);
    chk("t2_steps", stepCnt[0] - s0, 2);
    chk("t2_pvld", pvCnt[0] - p0, 1);
    chk("t2_period", perO[0], 1000);
    chk("t2_dir", dirO[0], 0);
    chk("t2_stall_drops_period", pvCnt[1] - p1, 0);

    s0 = stepCnt[0];
    hold(3'b100, DEB - 1);
    hold(3'b110, 30);
    chk("t3_glitch_steps", stepCnt[0] - s0, 0);
    chk("t3_glitch_sec", secO[0], 2);

    {hA, hB, hC} = 3'b100;
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (k == DEB) {hA, hB, hC} = 3'b110;
      @(negedge clk);
      if (stepO[0] && lat == 0) lat = k;
    end
    chk("t3_latency", lat, DEB + 3);
    hold(3'b110, 10);
    chk("t3_steps", stepCnt[0] - s0, 2);

    hold(3'b100, 50);
    hold(3'b101, 50);
    hold(3'b001, 50);
    hold(3'b011, 50);
    chk("t4_dir_rev", dirO[0], 1);
    chk("t4_sec", secO[0], 4);
    s0 = stepCnt[0]; p0 = pvCnt[0];
    hold(3'b001, 50);
    chk("t4_dir_fwd", dirO[0], 0);
    chk("t4_rev_steps", stepCnt[0] - s0, 1);
    chk("t4_rev_pvld", pvCnt[0] - p0, 0);

    hold(3'b111, 20);
    chk("t5_fault", faultO[0], 1);
    chk("t5_vld", vldO[0], 0);
    pulseClr();
    hold(3'b111, 5);
    chk("t5_clr_bad_code", faultO[0], 1);
    hold(3'b100, 20);
    pulseClr();
    chk("t5_clr_fault", faultO[0], 0);
    chk("t5_clr_vld_lag", vldO[0], 0);
    @(posedge clk);
    #1;
    chk("t5_clr_vld", vldO[0], 1);
    chk("t5_clr_sec", secO[0], 1);
    hold(3'b100, 5);
    hold(3'b101, 20);
    hold(3'b010, 20);
    chk("t5_jump_fault", faultO[0], 1);
    chk("t5_jump_vld", vldO[1], 0);
    hold(3'b100, 20);
    pulseClr();
    hold(3'b100, 5);
    chk("t5_jump_clr", faultO[0], 0);
    chk("t5_jump_sec", secO[0], 1);

    hold(3'b110, 150);
    chk("t6_stall", stallO[1], 1);
    chk("t6_nostall", stallO[0], 0);
    p1 = pvCnt[1];
    hold(3'b010, 50);
    chk("t6_stall_clr", stallO[1], 0);
    chk("t6_no_period", pvCnt[1] - p1, 0);
    hold(3'b011, 20);
    chk("t6_pvld", pvCnt[1] - p1, 1);
    chk("t6_period", perO[1], 50);

    @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    chk("t7_rst_vld", vldO[0], 0);
    chk("t7_rst_sec", secO[0], 0);
    @(posedge clk);
    #1;
    nRst = 1'b1;
    hold(3'b101, 20);
    chk("t7_resume_vld", vldO[0], 1);
    chk("t7_resume_sec", secO[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
